parking_allocator: RTL
======================

// Module: parking_allocator
// PURPOSE
//  Entry/exit controller for the 3-spot parking lot. It drives the per-spot occupancy
//  bits that spot counting consumes: occ[0]/occ[1]/occ[2] map to car1/car2/car3.
//  On each arrival request it assigns the lowest-numbered free spot, opens the entry
//  gate for a fixed time, and refuses entry when the lot is full. Departures free a spot.
// PARAMETERS
//  NUM_SPOTS        3  number of spots; occ width; index width IW = $clog2(NUM_SPOTS)
//  GATE_OPEN_CYCLES 4  cycles gate_open stays high per admitted car (>=1)
// PORTS
//  clk          in   1          single clock; all state updates on rising edge
//  reset_n      in   1          asynchronous, active-low reset
//  arrive       in   1          car at entry requests a spot; sampled each rising edge
//  depart       in   1          car leaving; sampled each rising edge
//  depart_spot  in   IW         spot index (0-based) being vacated when depart=1
//  occ          out  NUM_SPOTS  1 = spot taken; bit i = spot i+1
//  grant        out  1          one-cycle pulse: spot assigned to arriving car
//  grant_spot   out  IW         index of assigned spot; valid while grant=1, else holds
//  deny         out  1          one-cycle pulse: arrival refused, lot full
//  gate_open    out  1          entry gate open
//  full         out  1          combinational: &occ
//  err          out  1          one-cycle pulse: depart on already-free or out-of-range spot
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous): occ=0, grant=0, grant_spot=0, deny=0, gate_open=0,
//   err=0, pend=0, gate counter=0, state=IDLE. Outputs hold these values while reset_n=0.
//  States: IDLE, OPEN. All outputs except full are registered.
//  IDLE, request = arrive|pend:
//   - free spot exists in registered occ -> at the edge: set occ[k] (k = lowest free
//     index), grant=1, grant_spot=k, gate_open=1, counter=GATE_OPEN_CYCLES-1,
//     pend=0, go to OPEN. Latency is one edge from arrive sampled to grant visible.
//   - lot full and depart valid the same edge -> no deny; pend=1; serviced next cycle
//     using the freed spot.
//   - lot full and no valid depart -> deny=1 for one cycle; pend=0; stay IDLE.
//  OPEN: gate_open=1; counter decrements each edge. At the edge where counter==0,
//   gate_open=0 and state goes to IDLE. gate_open is high exactly GATE_OPEN_CYCLES cycles.
//   arrive seen in OPEN sets pend=1. pend is one deep; further arrivals are merged.
//  Departure, in any state: depart=1, spot in range, occ[depart_spot]=1 -> clear that
//   bit at the same edge. Free/out-of-range spot -> err=1 for one cycle, occ unchanged.
//  Same-edge allocation and departure: allocation uses pre-edge occ; clear and set hit
//   different bits, so both take effect.
//  grant, deny and err never stay high two consecutive cycles unless re-triggered.
//   grant and deny are mutually exclusive.
//  reset_n asserted mid-OPEN: gate closes at once; the pending request is discarded.
// TESTING
//  T1 reset_n=0 mid-run -> all outputs 0 asynchronously, before the next clk edge.
//  T2 empty lot, arrive pulse -> next cycle grant=1, grant_spot=0, occ=3'b001;
//     gate_open high exactly 4 cycles.
//  T3 occ=3'b101, arrive -> grant_spot=1, occ=3'b111, full=1.
//     Next arrive in IDLE -> deny=1 for one cycle, occ unchanged.
//  T4 full lot, arrive with depart=1, depart_spot=1 on the same edge -> occ=3'b101, no deny.
//     Next edge grant, grant_spot=1, occ=3'b111.
//  T5 arrive pulse during OPEN -> held; grant on the edge after gate_open falls.
//     Two arrivals during OPEN -> only one grant.
//  T6 depart with depart_spot=2 while occ=3'b011 -> err=1 for one cycle, occ stays 3'b011.
//     depart_spot=3 -> err=1, occ unchanged.

Source files
------------

// File: rtl/parking_allocator.sv
// rtl/parking_allocator.sv - entry/exit controller for a small parking lot
// Lowest-free-spot allocation, timed entry gate, deny when full, checked departures.
module parking_allocator #(
  parameter int NUM_SPOTS        = 3,
  parameter int GATE_OPEN_CYCLES = 4,
  localparam int IW = (NUM_SPOTS > 1) ? $clog2(NUM_SPOTS) : 1,
  localparam int CW = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 arrive,
  input  logic                 depart,
  input  logic [IW-1:0]        depart_spot,
  output logic [NUM_SPOTS-1:0] occ,
  output logic                 grant,
  output logic [IW-1:0]        grant_spot,
  output logic                 deny,
  output logic                 gate_open,
  output logic                 full,
  output logic                 err
);

  typedef enum logic {IDLE, OPEN} state_t;

  state_t                 state;
  logic                   pend;
  logic [CW-1:0]          cnt;

  logic                   free_found;
  logic [IW-1:0]          free_idx;
  logic [NUM_SPOTS-1:0]   dep_mask;
  logic                   dep_valid;
  logic [NUM_SPOTS-1:0]   clr_mask;
  logic [NUM_SPOTS-1:0]   set_mask;
  logic                   request;
  logic                   alloc;

  assign full = &occ;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    // Scan downward so the last hit, i.e. the lowest free index, wins.
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
    // An out-of-range index shifts the one-hot mask to zero, so it never matches occ.
    dep_mask  = NUM_SPOTS'(1) << depart_spot;
    dep_valid = depart && ((occ & dep_mask) != '0);
    clr_mask  = dep_valid ? dep_mask : '0;
    set_mask  = NUM_SPOTS'(1) << free_idx;
    request   = arrive | pend;
    alloc     = (state == IDLE) && request && free_found;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pend       <= 1'b0;
      cnt        <= '0;
      occ        <= '0;
      grant      <= 1'b0;
      grant_spot <= '0;
      deny       <= 1'b0;
      gate_open  <= 1'b0;
      err        <= 1'b0;
    end else begin
      grant <= 1'b0;
      deny  <= 1'b0;
      err   <= depart && !dep_valid;
      // Allocation sees pre-edge occ; clear and set target different bits.
      occ   <= (occ & ~clr_mask) | (alloc ? set_mask : '0);

      case (state)
        IDLE: begin
          if (request) begin
            if (free_found) begin
              grant      <= 1'b1;
              grant_spot <= free_idx;
              gate_open  <= 1'b1;
              cnt        <= CW'(GATE_OPEN_CYCLES - 1);
              pend       <= 1'b0;
              state      <= OPEN;
            end else if (dep_valid) begin
              // A spot frees this edge; retry next cycle instead of refusing.
              pend <= 1'b1;
            end else begin
              deny <= 1'b1;
              pend <= 1'b0;
            end
          end
        end
        OPEN: begin
          if (arrive) pend <= 1'b1;
          if (cnt == '0) begin
            gate_open <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
